// File: rtl/rgb_sframe.sv
// rgb_sframe: WS2812-style serial framer, pulse-length bit decode into pixel words.
// Ports: clk/rst (sync, active-high), sig (async pin) -> strobe/sbit_value per bit,
//   pixel_data/pixel_valid/pixel_idx per pixel, stream_reset pulse, sticky frame_err.
module rgb_sframe #(
  parameter int BITS_PER_PIXEL    = 24,
  parameter int SYNC_STAGES       = 2,
  parameter int SAMPLE_TIME_CLKS  = 57,
  parameter int MIN_HIGH_CLKS     = 24,
  parameter int MAX_HIGH_CLKS     = 200,
  parameter int STREAM_RESET_CLKS = 4800,
  parameter int CNT_W             = 13,
  parameter int PIX_IDX_W         = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sig,
  output logic                      strobe,
  output logic                      sbit_value,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      pixel_valid,
  output logic [PIX_IDX_W-1:0]      pixel_idx,
  output logic                      stream_reset,
  output logic                      frame_err
);

  localparam int BC_W = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [1:0] ST_LOW  = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_HUNG = 2'd2;

  localparam logic [CNT_W-1:0] SR_C   = CNT_W'(STREAM_RESET_CLKS);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_HIGH_CLKS);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_HIGH_CLKS);
  localparam logic [CNT_W-1:0] SMP_C  = CNT_W'(SAMPLE_TIME_CLKS);
  localparam logic [BC_W-1:0]  LAST_B = BC_W'(BITS_PER_PIXEL - 1);

  logic [SYNC_STAGES-1:0]    sync_q;
  logic                      s;
  logic                      s_prev;
  logic                      rise;
  logic                      fall;
  logic                      edge_s;
  logic [CNT_W-1:0]          cnt;
  logic [1:0]                state;
  logic [BC_W-1:0]           bit_cnt;
  logic [BITS_PER_PIXEL-1:0] shreg;
  logic [PIX_IDX_W-1:0]      pend_idx;
  logic                      bit_v;
  logic [BITS_PER_PIXEL-1:0] word_next;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_prev;
  assign fall      = ~s & s_prev;
  assign edge_s    = rise | fall;
  // At the first low cycle cnt holds exactly the high length.
  assign bit_v     = (cnt > SMP_C);
  assign word_next = {shreg[BITS_PER_PIXEL-2:0], bit_v};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      s_prev <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (edge_s) begin
      cnt <= CNT_W'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_LOW;
      bit_cnt      <= '0;
      shreg        <= '0;
      pend_idx     <= '0;
      strobe       <= 1'b0;
      sbit_value   <= 1'b0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      pixel_idx    <= '0;
      stream_reset <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      strobe       <= 1'b0;
      pixel_valid  <= 1'b0;
      stream_reset <= 1'b0;
      case (state)
        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
          end else if (cnt == SR_C) begin
            stream_reset <= 1'b1;
            bit_cnt      <= '0;
            shreg        <= '0;
            pend_idx     <= '0;
            frame_err    <= 1'b0;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
            if (cnt < MIN_C) begin
              frame_err <= 1'b1;
            end else begin
              strobe     <= 1'b1;
              sbit_value <= bit_v;
              shreg      <= word_next;
              if (bit_cnt == LAST_B) begin
                bit_cnt     <= '0;
                pixel_data  <= word_next;
                pixel_valid <= 1'b1;
                pixel_idx   <= pend_idx;
                if (pend_idx != '1) begin
                  pend_idx <= pend_idx + PIX_IDX_W'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + BC_W'(1);
              end
            end
          end else if (cnt == MAX_C) begin
            frame_err <= 1'b1;
            state     <= ST_HUNG;
          end
        end
        ST_HUNG: begin
          // Pulse is abandoned; only a stuck-high stream reset or release.
          if (fall) begin
            state <= ST_LOW;
          end else if (cnt == SR_C) begin
            stream_reset <= 1'b1;
            bit_cnt      <= '0;
            shreg        <= '0;
            pend_idx     <= '0;
            frame_err    <= 1'b0;
          end
        end
        default: state <= ST_LOW;
      endcase
    end
  end

endmodule
